// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller and the datapath:
// FSM states, opcode/funct values, ALUControl codes and mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States whose exit edge completes (retires) an instruction.
  function automatic logic is_terminal(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: ALUOp class plus funct field to ALUControl,
// with a flag telling whether the funct is one the core supports.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_valid_o
);

  logic [2:0] fn_ctl;

  always_comb begin
    fn_ctl        = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  fn_ctl = ALU_ADD;
      FN_SUB:  fn_ctl = ALU_SUB;
      FN_AND:  fn_ctl = ALU_AND;
      FN_OR:   fn_ctl = ALU_OR;
      FN_SLT:  fn_ctl = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD:   alu_control_o = ALU_ADD;
      ALUOP_SUB:   alu_control_o = ALU_SUB;
      ALUOP_FUNCT: alu_control_o = fn_ctl;
      default:     alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore controller for the multicycle MIPS core: sequences each instruction,
// counts retired instructions and latches a sticky illegal-instruction flag.
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 Control_Unit_CLK,
  input  logic                 Control_Unit_RST,
  input  logic [5:0]           Opcode,
  input  logic [5:0]           Funct,
  input  logic                 Zero_flag,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic [2:0]           ALUControl,
  output logic                 PCEn,
  output logic                 Illegal_Op,
  output logic [CNT_WIDTH-1:0] Instr_Retired,
  output logic [3:0]           State_dbg
);

  state_t               state_q, state_d;
  logic [5:0]           opcode_q, opcode_d;
  logic [5:0]           funct_q, funct_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  aluop_t     alu_op;
  logic       alu_en;
  logic [5:0] dec_funct;
  logic [2:0] dec_ctl;
  logic       funct_valid;

  // Live funct is only looked at in DECODE; later states use the latched copy.
  assign dec_funct = (state_q == S_DECODE) ? Funct : funct_q;

  alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct_i       (dec_funct),
    .alu_control_o (dec_ctl),
    .funct_valid_o (funct_valid)
  );

  always_ff @(posedge Control_Unit_CLK or posedge Control_Unit_RST) begin
    if (Control_Unit_RST) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = Opcode;
        funct_d  = Funct;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid) begin
              state_d = S_EXECUTE;
            end else begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
    if (is_terminal(state_q)) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
  end

  // Outputs depend on state only, so reset forces IDLE values immediately.
  always_comb begin
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REGB;
    PCSrc    = PCSRC_ALURES;
    alu_op   = ALUOP_ADD;
    alu_en   = 1'b0;
    case (state_q)
      S_IDLE: alu_en = 1'b1;
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        alu_en  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        alu_en  = 1'b1;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_en  = 1'b1;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        alu_en  = 1'b1;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        alu_en  = 1'b1;
        PCSrc   = PCSRC_ALUOUT;
        Branch  = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUControl    = alu_en ? dec_ctl : 3'b000;
  assign PCEn          = PCWrite | (Branch & Zero_flag);
  assign Illegal_Op    = illegal_q;
  assign Instr_Retired = retired_q;
  assign State_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle control-word vectors for each
// instruction class, reset corner cases, then random instructions vs a model.
module tb_multicycle_control_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode, funct;
  logic          zero;
  logic          iord, irwrite, pcwrite, branch, memwrite, regwrite;
  logic          regdst, memtoreg, alusrca, pcen, illegal_op;
  logic [1:0]    alusrcb, pcsrc;
  logic [2:0]    aluctl;
  logic [CW-1:0] retired;
  logic [3:0]    state_dbg;

  multicycle_control_unit #(.CNT_WIDTH(CW)) dut (
    .Control_Unit_CLK (clk),
    .Control_Unit_RST (rst),
    .Opcode           (opcode),
    .Funct            (funct),
    .Zero_flag        (zero),
    .IorD             (iord),
    .IRWrite          (irwrite),
    .PCWrite          (pcwrite),
    .Branch           (branch),
    .MemWrite         (memwrite),
    .RegWrite         (regwrite),
    .RegDst           (regdst),
    .MemtoReg         (memtoreg),
    .ALUSrcA          (alusrca),
    .ALUSrcB          (alusrcb),
    .PCSrc            (pcsrc),
    .ALUControl       (aluctl),
    .PCEn             (pcen),
    .Illegal_Op       (illegal_op),
    .Instr_Retired    (retired),
    .State_dbg        (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Control word: {IorD,IRWrite,PCWrite,Branch,MemWrite,RegWrite,RegDst,
  //                MemtoReg,ALUSrcA,ALUSrcB,PCSrc,ALUControl,PCEn}
  localparam logic [16:0] W_IDLE   = 17'b0_0_0_0_0_0_0_0_0_00_00_010_0;
  localparam logic [16:0] W_FETCH  = 17'b0_1_1_0_0_0_0_0_0_01_00_010_1;
  localparam logic [16:0] W_DECODE = 17'b0_0_0_0_0_0_0_0_0_11_00_010_0;
  localparam logic [16:0] W_MEMADR = 17'b0_0_0_0_0_0_0_0_1_10_00_010_0;
  localparam logic [16:0] W_MEMRD  = 17'b1_0_0_0_0_0_0_0_0_00_00_000_0;
  localparam logic [16:0] W_MEMWB  = 17'b0_0_0_0_0_1_0_1_0_00_00_000_0;
  localparam logic [16:0] W_MEMWR  = 17'b1_0_0_0_1_0_0_0_0_00_00_000_0;
  localparam logic [16:0] W_ALUWB  = 17'b0_0_0_0_0_1_1_0_0_00_00_000_0;
  localparam logic [16:0] W_ADDIWB = 17'b0_0_0_0_0_1_0_0_0_00_00_000_0;
  localparam logic [16:0] W_JUMP   = 17'b0_0_1_0_0_0_0_0_0_00_10_000_1;
  localparam logic [16:0] W_BR1    = 17'b0_0_0_1_0_0_0_0_1_00_01_110_1;
  localparam logic [16:0] W_BR0    = 17'b0_0_0_1_0_0_0_0_1_00_01_110_0;

  function automatic logic [16:0] w_exec(input logic [2:0] alu);
    return {9'b0_0_0_0_0_0_0_0_1, 4'b0000, alu, 1'b0};
  endfunction

  function automatic logic [16:0] obs();
    return {iord, irwrite, pcwrite, branch, memwrite, regwrite, regdst,
            memtoreg, alusrca, alusrcb, pcsrc, aluctl, pcen};
  endfunction

  typedef struct {
    string            name;
    logic [5:0]       op;
    logic [5:0]       fn;
    logic             z;
    int               n;
    logic             ill;
    logic [4:0][16:0] w;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [5:0] op,
                              input logic [5:0] fn, input logic z, input int n,
                              input logic ill, input logic [16:0] w0,
                              input logic [16:0] w1, input logic [16:0] w2,
                              input logic [16:0] w3, input logic [16:0] w4);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.z = z; v.n = n; v.ill = ill;
    v.w = {w4, w3, w2, w1, w0};
    return v;
  endfunction

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [17:0]   exp_q[$];
  logic [CW-1:0] exp_ret;
  logic          exp_ill;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] fn_alu(input logic [5:0] fn, output logic ok);
    ok = 1'b1;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default: begin ok = 1'b0; return 3'b000; end
    endcase
  endfunction

  // Instruction-level view: length in cycles and how many times each
  // architectural effect (reg write, mem write, PC redirect) happens.
  task automatic model(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, output int len, output int rw,
                       output int mw, output int pe, output logic ill);
    logic ok;
    logic [2:0] dummy;
    len = 2; rw = 0; mw = 0; pe = 0; ill = 1'b0;
    dummy = fn_alu(fn, ok);
    case (op)
      6'b100011: begin len = 5; rw = 1; end
      6'b101011: begin len = 4; mw = 1; end
      6'b000000: if (ok) begin len = 4; rw = 1; end else ill = 1'b1;
      6'b000100: begin len = 3; pe = z ? 1 : 0; end
      6'b001000: begin len = 4; rw = 1; end
      6'b000010: begin len = 3; pe = 1; end
      default:   ill = 1'b1;
    endcase
  endtask

  vec_t vecs[13];

  // ---------------- test ----------------
  initial begin
    int len, rw, mw, pe, cyc, orw, omw, ope;
    logic ill, ok;
    logic [5:0] op, fn;
    logic z;
    logic [2:0] ealu, alu_seen;
    logic [17:0] expv, gotv;

    vecs[0]  = mk("lw",      6'b100011, 6'b000000, 0, 5, 0, W_FETCH, W_DECODE, W_MEMADR, W_MEMRD, W_MEMWB);
    vecs[1]  = mk("sw",      6'b101011, 6'b000000, 0, 4, 0, W_FETCH, W_DECODE, W_MEMADR, W_MEMWR, W_IDLE);
    vecs[2]  = mk("r_slt",   6'b000000, 6'b101010, 0, 4, 0, W_FETCH, W_DECODE, w_exec(3'b111), W_ALUWB, W_IDLE);
    vecs[3]  = mk("r_sub",   6'b000000, 6'b100010, 0, 4, 0, W_FETCH, W_DECODE, w_exec(3'b110), W_ALUWB, W_IDLE);
    vecs[4]  = mk("r_add",   6'b000000, 6'b100000, 1, 4, 0, W_FETCH, W_DECODE, w_exec(3'b010), W_ALUWB, W_IDLE);
    vecs[5]  = mk("r_and",   6'b000000, 6'b100100, 0, 4, 0, W_FETCH, W_DECODE, w_exec(3'b000), W_ALUWB, W_IDLE);
    vecs[6]  = mk("r_or",    6'b000000, 6'b100101, 0, 4, 0, W_FETCH, W_DECODE, w_exec(3'b001), W_ALUWB, W_IDLE);
    vecs[7]  = mk("beq_z1",  6'b000100, 6'b000000, 1, 3, 0, W_FETCH, W_DECODE, W_BR1, W_IDLE, W_IDLE);
    vecs[8]  = mk("beq_z0",  6'b000100, 6'b000000, 0, 3, 0, W_FETCH, W_DECODE, W_BR0, W_IDLE, W_IDLE);
    vecs[9]  = mk("addi",    6'b001000, 6'b000000, 0, 4, 0, W_FETCH, W_DECODE, W_MEMADR, W_ADDIWB, W_IDLE);
    vecs[10] = mk("j",       6'b000010, 6'b000000, 1, 3, 0, W_FETCH, W_DECODE, W_JUMP, W_IDLE, W_IDLE);
    vecs[11] = mk("ill_op",  6'b111111, 6'b000000, 0, 2, 1, W_FETCH, W_DECODE, W_IDLE, W_IDLE, W_IDLE);
    vecs[12] = mk("ill_fn",  6'b000000, 6'b000111, 0, 2, 1, W_FETCH, W_DECODE, W_IDLE, W_IDLE, W_IDLE);

    // Reset held for 3 cycles, then one IDLE cycle before FETCH.
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0;
    exp_ret = '0; exp_ill = 1'b0;
    #1;
    chk("reset_word_async", 32'(obs()), 32'(W_IDLE));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_word", 32'(obs()), 32'(W_IDLE));
    end
    chk("reset_retired", 32'(retired), 32'(exp_ret));
    chk("reset_illegal", 32'(illegal_op), 32'(exp_ill));
    rst = 1'b0;
    #1;
    chk("idle_after_release", 32'(obs()), 32'(W_IDLE));
    step();
    chk("first_fetch", 32'(obs()), 32'(W_FETCH));

    // Per-cycle vectors; instruction fields are scrambled after DECODE.
    for (int v = 0; v < 13; v++) begin
      opcode = vecs[v].op; funct = vecs[v].fn; zero = vecs[v].z;
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i >= 2) begin
          opcode = ~vecs[v].op;
          funct  = ~vecs[v].fn;
        end
        chk($sformatf("%s_c%0d", vecs[v].name, i), 32'(obs()), 32'(vecs[v].w[i]));
        step();
      end
      if (!vecs[v].ill) exp_ret = exp_ret + 1'b1;
      exp_ill = exp_ill | vecs[v].ill;
      chk($sformatf("%s_retired", vecs[v].name), 32'(retired), 32'(exp_ret));
      chk($sformatf("%s_illegal", vecs[v].name), 32'(illegal_op), 32'(exp_ill));
    end

    // Reset during MEMWR of a sw: write strobe must drop at once.
    opcode = 6'b101011; funct = '0; zero = 1'b0;
    step(); step(); step();
    chk("midsw_memwrite_before", 32'(memwrite), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midsw_word_async", 32'(obs()), 32'(W_IDLE));
    chk("midsw_retired", 32'(retired), 32'd0);
    chk("midsw_illegal", 32'(illegal_op), 32'd0);
    exp_ret = '0; exp_ill = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("midsw_idle", 32'(obs()), 32'(W_IDLE));
    step();
    chk("midsw_fetch", 32'(obs()), 32'(W_FETCH));

    // Random instructions vs the instruction-level model (counter wraps at 2^CW).
    for (int k = 0; k < 300; k++) begin
      fn = 6'($urandom);
      z  = 1'($urandom);
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: begin
          op = 6'b000000;
          case ($urandom_range(0, 4))
            0: fn = 6'b100000;
            1: fn = 6'b100010;
            2: fn = 6'b100100;
            3: fn = 6'b100101;
            default: fn = 6'b101010;
          endcase
        end
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        6: begin
          op = 6'b000000;
          ealu = fn_alu(fn, ok);
          while (ok) begin
            fn = fn + 6'd1;
            ealu = fn_alu(fn, ok);
          end
        end
        default: op = 6'($urandom);
      endcase
      model(op, fn, z, len, rw, mw, pe, ill);
      ealu = fn_alu(fn, ok);
      if (!ill) exp_ret = exp_ret + 1'b1;
      exp_ill = exp_ill | ill;
      exp_q.push_back({4'(len), 3'(rw), 3'(mw), 3'(pe), exp_ret, exp_ill});

      opcode = op; funct = fn; zero = z;
      cyc = 0; orw = 0; omw = 0; ope = 0; alu_seen = 3'b000;
      do begin
        if (cyc >= 2) begin
          opcode = 6'($urandom);
          funct  = 6'($urandom);
        end
        if (cyc == 2) alu_seen = aluctl;
        orw += int'(regwrite);
        omw += int'(memwrite);
        if (cyc > 0) ope += int'(pcen);
        step();
        cyc++;
      end while (!irwrite && cyc < 8);

      if (op == 6'b000000 && ok)
        chk($sformatf("rnd%0d_alu", k), 32'(alu_seen), 32'(ealu));
      gotv = {4'(cyc), 3'(orw), 3'(omw), 3'(ope), retired, illegal_op};
      expv = exp_q.pop_front();
      chk($sformatf("rnd%0d_op%b_fn%b", k, op, fn), 32'(gotv), 32'(expv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style finite-state controller for the multicycle MIPS core. It consumes `Opcode` and `Funct` from the held instruction register and `Zero_flag` from the ALU. It drives every datapath strobe and mux select, sequencing each instruction over 3–5 cycles. It also keeps a retired-instruction counter and a sticky illegal-instruction flag for bring-up.

## Interface
Parameters:
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.

Ports:
- `Control_Unit_CLK`  in  1  single clock; all state changes on its rising edge.
- `Control_Unit_RST`  in  1  reset; asynchronous, active-high.
- `Opcode`  in  6  Instr[31:26]; stable from DECODE onward.
- `Funct`  in  6  Instr[5:0].
- `Zero_flag`  in  1  ALU zero output.
- `IorD`, `IRWrite`, `PCWrite`, `Branch`, `MemWrite`, `RegWrite`, `RegDst`, `MemtoReg`, `ALUSrcA`  out  1 each  datapath strobes and selects.
- `ALUSrcB`  out  2  00 = RegB, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- `PCSrc`  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `ALUControl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `PCEn`  out  1  `PCWrite | (Branch & Zero_flag)`; combinational.
- `Illegal_Op`  out  1  sticky flag set on an unsupported opcode or funct.
- `Instr_Retired`  out  CNT_WIDTH  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Transitions:
  - IDLE → FETCH unconditionally.
  - FETCH → DECODE.
  - DECODE branches on opcode:
    - lw 100011 / sw 101011 → MEMADR
    - R-type 000000 with supported funct → EXECUTE
    - beq 000100 → BRANCH
    - addi 001000 → ADDIEX
    - j 000010 → JUMP
    - anything else → FETCH, setting `Illegal_Op`.
  - MEMADR → MEMRD (lw) or MEMWR (sw). MEMRD → MEMWB.
  - EXECUTE → ALUWB. ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
- Supported funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010. Any other funct is illegal.
- Outputs are a pure function of state; any output not listed below is 0.
  - IDLE: all strobes 0; ALUControl = 010.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=add.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=add.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from funct decode.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=sub, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=add.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- `Instr_Retired` increments by 1 on every transition from a terminal state into FETCH. It wraps modulo 2^CNT_WIDTH.
- Illegal-instruction rules:
  - An illegal-opcode return to FETCH does not increment `Instr_Retired`.
  - `Illegal_Op` is cleared only by reset.

## Timing
- Reset asserted: state = IDLE, `Illegal_Op` = 0, `Instr_Retired` = 0. All outputs take IDLE values immediately, asynchronously.
- Reset released: one IDLE cycle, then FETCH on the next edge.
- Reset mid-instruction: abandon immediately. No partial write strobe survives past reset assertion.
- Cycles per instruction, FETCH through the last state inclusive:
  - lw 5
  - sw 4, R-type 4, addi 4
  - beq 3, j 3
  - illegal 2
- `Zero_flag` is used only in BRANCH, same cycle, through `PCEn`. No registering.
- `Opcode` and `Funct` are sampled in DECODE only. Changes in later states are ignored.
- Counter update and the `Illegal_Op` set both occur on the clock edge leaving the respective state.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the state enum
  - opcode and funct constants
  - ALUControl encodings
  - ALUSrcB and PCSrc encodings
- The datapath side reuses the ALUControl and select encodings from this package.
- Sub-module `alu_decoder` (combinational): ALUOp class {add, sub, funct} plus `Funct` → `ALUControl` and a `funct_valid` output.
- The main FSM owns the state register, the counter and the flag.

## Test plan
- Reset: hold RST high for 3 cycles then release → all strobes 0 during reset; 1 IDLE cycle; FETCH shows IRWrite=1, PCWrite=1, ALUSrcB=01.
- lw sequence: Opcode=100011 → FETCH, DECODE, MEMADR, MEMRD, MEMWB in 5 cycles; MemtoReg=1 and RegWrite=1 in the 5th cycle; `Instr_Retired` 0→1.
- R-type: Opcode=000000, Funct=101010 → ALUControl=111 in EXECUTE, RegDst=1 in ALUWB. Repeat with Funct=100010 → 110.
- beq: Zero_flag=1 → PCEn=1 with PCSrc=01 in BRANCH; Zero_flag=0 → PCEn=0; both retire in 3 cycles.
- Illegal: Opcode=111111 → back to FETCH after DECODE, `Illegal_Op`=1 and sticky, counter unchanged. Same behaviour for Opcode=000000 with Funct=000111.
- Reset mid-sw: assert RST during MEMWR → MemWrite drops to 0 asynchronously; counter resets to 0; restart via IDLE.
